// File: rtl/lock_pkg.sv
// Shared types and default sizes for the code lock entry path and checker.
// Exports: entry_state_t, LOCK_PW_LEN, LOCK_BITS_W.
package lock_pkg;

    localparam int LOCK_PW_LEN = 4;
    localparam int LOCK_BITS_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DIGIT_OUT,
        SUBMIT_OUT
    } entry_state_t;

endpackage

// File: rtl/code_entry_tx_if.sv
// Valid/ready transfer bundle from the entry front end to the checker.
// master drives digit/submit transfers, slave returns tx_ready.
interface code_entry_tx_if
    import lock_pkg::*;
#(
    parameter int PW_LEN = LOCK_PW_LEN,
    parameter int BITS_W = LOCK_BITS_W
);
    localparam int IDX_W = $clog2(PW_LEN);

    logic              tx_ready;
    logic              digit_valid;
    logic [BITS_W-1:0] digit;
    logic [IDX_W-1:0]  digit_index;
    logic              submit_valid;
    logic [IDX_W:0]    submit_len;

    modport master (
        input  tx_ready,
        output digit_valid, digit, digit_index,
        output submit_valid, submit_len
    );

    modport slave (
        output tx_ready,
        input  digit_valid, digit, digit_index,
        input  submit_valid, submit_len
    );

endinterface

// File: rtl/key_debounce.sv
// Debouncer for one raw active-low button: 2-FF sync, hold counter, press pulse.
// Ports: clk, system_reset_n, key_n (raw), press (one cycle per accepted press).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic system_reset_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    // level is the accepted (debounced) active-low state; 1 = released
    always_ff @(posedge clk) begin
        if (!system_reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/code_entry_tx.sv
// Code entry front end: debounced buttons to indexed digit/submit transfers.
// Ports: clk, system_reset_n, key_*_n, bits, tx (master), clear_pulse,
// entry_count, err_pulse.
module code_entry_tx
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PW_LEN          = LOCK_PW_LEN,
    parameter int BITS_W          = LOCK_BITS_W,
    parameter int IDX_W           = $clog2(PW_LEN)
) (
    input  logic              clk,
    input  logic              system_reset_n,
    input  logic              key_digit_n,
    input  logic              key_submit_n,
    input  logic              key_clear_n,
    input  logic [BITS_W-1:0] bits,
    code_entry_tx_if.master   tx,
    output logic              clear_pulse,
    output logic [IDX_W:0]    entry_count,
    output logic              err_pulse
);
    logic dig_press, sub_press, clr_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dig (
        .clk(clk), .system_reset_n(system_reset_n),
        .key_n(key_digit_n), .press(dig_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sub (
        .clk(clk), .system_reset_n(system_reset_n),
        .key_n(key_submit_n), .press(sub_press)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .system_reset_n(system_reset_n),
        .key_n(key_clear_n), .press(clr_press)
    );

    entry_state_t      state, state_n;
    logic [IDX_W:0]    count, count_n;
    logic [BITS_W-1:0] digit_q, digit_n;
    logic [IDX_W-1:0]  index_q, index_n;
    logic [IDX_W:0]    slen_q, slen_n;
    logic              dvalid, dvalid_n;
    logic              svalid, svalid_n;
    logic              clr_q, clr_n;
    logic              err_q, err_n;
    logic              busy;
    logic              full;

    assign busy = (state == DIGIT_OUT) || (state == SUBMIT_OUT);
    assign full = (count == (IDX_W+1)'(PW_LEN));

    always_ff @(posedge clk) begin
        if (!system_reset_n) begin
            state   <= IDLE;
            count   <= '0;
            digit_q <= '0;
            index_q <= '0;
            slen_q  <= '0;
            dvalid  <= 1'b0;
            svalid  <= 1'b0;
            clr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            digit_q <= digit_n;
            index_q <= index_n;
            slen_q  <= slen_n;
            dvalid  <= dvalid_n;
            svalid  <= svalid_n;
            clr_q   <= clr_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        count_n  = count;
        digit_n  = digit_q;
        index_n  = index_q;
        slen_n   = slen_q;
        dvalid_n = dvalid;
        svalid_n = svalid;
        clr_n    = 1'b0;
        err_n    = 1'b0;

        // Handshake completion first; a clear below may still abort it.
        unique case (state)
            DIGIT_OUT: if (tx.tx_ready) begin
                dvalid_n = 1'b0;
                count_n  = count + (IDX_W+1)'(1);
                state_n  = COLLECT;
            end
            SUBMIT_OUT: if (tx.tx_ready) begin
                svalid_n = 1'b0;
                count_n  = '0;
                state_n  = IDLE;
            end
            default: ;
        endcase

        // clear > submit > digit; lower presses in the same cycle vanish
        if (clr_press) begin
            state_n  = IDLE;
            count_n  = '0;
            dvalid_n = 1'b0;
            svalid_n = 1'b0;
            clr_n    = 1'b1;
        end else if (sub_press) begin
            if (busy || state == IDLE) begin
                err_n = 1'b1;
            end else begin
                slen_n   = count;
                svalid_n = 1'b1;
                state_n  = SUBMIT_OUT;
            end
        end else if (dig_press) begin
            if (busy || full) begin
                err_n = 1'b1;
            end else begin
                digit_n  = bits;
                index_n  = count[IDX_W-1:0];
                dvalid_n = 1'b1;
                state_n  = DIGIT_OUT;
            end
        end
    end

    assign tx.digit_valid  = dvalid;
    assign tx.digit        = digit_q;
    assign tx.digit_index  = index_q;
    assign tx.submit_valid = svalid;
    assign tx.submit_len   = slen_q;
    assign clear_pulse     = clr_q;
    assign entry_count     = count;
    assign err_pulse       = err_q;

endmodule

// File: tb/tb_code_entry_tx.sv
// Scoreboard bench for code_entry_tx: expected transfers queued at press time,
// compared while valid is high, popped on handshake or abort.
module tb_code_entry_tx;
    import lock_pkg::*;

    localparam int D = 16;

    typedef struct {
        bit is_sub;
        int val;
        int idx;
        int hold;
        bit abort;
    } item_t;

    logic       clk = 1'b0;
    logic       system_reset_n = 1'b0;
    logic       key_digit_n = 1'b1;
    logic       key_submit_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [1:0] bits = 2'b00;
    logic       clear_pulse;
    logic [2:0] entry_count;
    logic       err_pulse;

    code_entry_tx_if #(.PW_LEN(4), .BITS_W(2)) tx ();

    code_entry_tx #(.DEBOUNCE_CYCLES(D), .PW_LEN(4), .BITS_W(2)) dut (
        .clk(clk),
        .system_reset_n(system_reset_n),
        .key_digit_n(key_digit_n),
        .key_submit_n(key_submit_n),
        .key_clear_n(key_clear_n),
        .bits(bits),
        .tx(tx),
        .clear_pulse(clear_pulse),
        .entry_count(entry_count),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    last_cyc = 0;
    int    rise_cyc = 0;
    int    err_cnt = 0;
    int    clr_cnt = 0;
    int    err_exp = 0;
    int    clr_exp = 0;
    int    vc = 0;
    bit    pv = 0;
    bit    phs = 0;
    item_t q[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / ready driver
    always @(negedge clk) begin
        bit    v;
        item_t it;
        v = tx.digit_valid || tx.submit_valid;
        if (v && !pv) rise_cyc = cyc;
        if (pv && !phs && !v) begin
            if (q.size() == 0) check("abort_unexp", 1, 0);
            else begin
                it = q.pop_front();
                check("abort_exp", 1, 32'(it.abort));
            end
            vc = 0;
        end
        if (v) begin
            if (q.size() == 0) begin
                check("unexpected_tx", 1, 0);
                tx.tx_ready = 1'b1;
            end else begin
                it = q[0];
                vc++;
                check("dv", 32'(tx.digit_valid), 32'(!it.is_sub));
                check("sv", 32'(tx.submit_valid), 32'(it.is_sub));
                if (it.is_sub) check("slen", 32'(tx.submit_len), it.val);
                else begin
                    check("digit", 32'(tx.digit), it.val);
                    check("index", 32'(tx.digit_index), it.idx);
                end
                tx.tx_ready = (vc > it.hold);
                if (tx.tx_ready) begin
                    check("hold", vc, it.hold + 1);
                    check("abort_none", 0, 32'(it.abort));
                    void'(q.pop_front());
                    vc = 0;
                end
            end
        end else begin
            tx.tx_ready = 1'b1;
            vc = 0;
        end
        pv  = v;
        phs = v && tx.tx_ready;
        if (system_reset_n) check("excl", 32'(tx.digit_valid && tx.submit_valid), 0);
        if (err_pulse) err_cnt++;
        if (clear_pulse) begin
            clr_cnt++;
            check("clr_drop", 32'(tx.digit_valid || tx.submit_valid), 0);
        end
    end

    task automatic press(input logic [2:0] m, input int len);
        @(negedge clk);
        key_digit_n  = !m[0];
        key_submit_n = !m[1];
        key_clear_n  = !m[2];
        last_cyc = cyc;
        repeat (len) @(negedge clk);
        key_digit_n  = 1'b1;
        key_submit_n = 1'b1;
        key_clear_n  = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic push(input bit s, input int val, input int idx,
                        input int hold, input bit ab);
        item_t it;
        it.is_sub = s;
        it.val    = val;
        it.idx    = idx;
        it.hold   = hold;
        it.abort  = ab;
        q.push_back(it);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dv"}, 32'(tx.digit_valid), 0);
        check({tag, "_sv"}, 32'(tx.submit_valid), 0);
        check({tag, "_dig"}, 32'(tx.digit), 0);
        check({tag, "_idx"}, 32'(tx.digit_index), 0);
        check({tag, "_slen"}, 32'(tx.submit_len), 0);
        check({tag, "_clr"}, 32'(clear_pulse), 0);
        check({tag, "_err"}, 32'(err_pulse), 0);
        check({tag, "_cnt"}, 32'(entry_count), 0);
    endtask

    localparam logic [2:0] K_DIG = 3'b001;
    localparam logic [2:0] K_SUB = 3'b010;
    localparam logic [2:0] K_CLR = 3'b100;

    initial begin
        int ds[4];
        ds = '{3, 1, 0, 2};
        tx.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        system_reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // single digit, latency
        bits = 2'b10;
        push(0, 2, 0, 0, 0);
        press(K_DIG, 20);
        check("lat_digit", rise_cyc - last_cyc, 20);
        check("cnt_1", 32'(entry_count), 1);
        press(K_CLR, 20);
        clr_exp++;
        check("cnt_clr", 32'(entry_count), 0);

        // glitch
        press(K_DIG, 5);
        check("glitch_cnt", 32'(entry_count), 0);
        check("glitch_err", err_cnt, err_exp);

        // four held digits, then overflow
        for (int i = 0; i < 4; i++) begin
            bits = 2'(ds[i]);
            push(0, ds[i], i, 4, 0);
            press(K_DIG, 20);
        end
        check("cnt_4", 32'(entry_count), 4);
        press(K_DIG, 20);
        err_exp++;
        check("ovf_err", err_cnt, err_exp);
        check("ovf_cnt", 32'(entry_count), 4);
        press(K_CLR, 20);
        clr_exp++;

        // two digits, submit, submit again
        for (int i = 0; i < 2; i++) begin
            bits = 2'(i + 1);
            push(0, i + 1, i, 0, 0);
            press(K_DIG, 20);
        end
        push(1, 2, 0, 0, 0);
        press(K_SUB, 20);
        check("sub_cnt", 32'(entry_count), 0);
        press(K_SUB, 20);
        err_exp++;
        check("sub_idle_err", err_cnt, err_exp);

        // clear aborts pending digit
        bits = 2'b11;
        push(0, 3, 0, 1000, 1);
        press(K_DIG, 20);
        press(K_CLR, 20);
        clr_exp++;
        check("abort_cnt", 32'(entry_count), 0);
        check("abort_clr", clr_cnt, clr_exp);

        // clear + submit together
        bits = 2'b01;
        push(0, 1, 0, 0, 0);
        press(K_DIG, 20);
        press(K_CLR | K_SUB, 20);
        clr_exp++;
        check("cs_clr", clr_cnt, clr_exp);
        check("cs_err", err_cnt, err_exp);
        check("cs_cnt", 32'(entry_count), 0);

        // reset mid submit
        bits = 2'b10;
        push(0, 2, 0, 0, 0);
        press(K_DIG, 20);
        push(1, 1, 0, 1000, 1);
        press(K_SUB, 20);
        system_reset_n = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");

        // button held through reset release
        bits = 2'b01;
        push(0, 1, 0, 0, 0);
        key_digit_n = 1'b0;
        repeat (3) @(negedge clk);
        system_reset_n = 1'b1;
        last_cyc = cyc;
        repeat (20) @(negedge clk);
        key_digit_n = 1'b1;
        repeat (24) @(negedge clk);
        check("lat_rst", rise_cyc - last_cyc, 20);
        check("rst_cnt", 32'(entry_count), 1);

        check("err_total", err_cnt, err_exp);
        check("clr_total", clr_cnt, clr_exp);
        check("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
